panda_risc_v_lit_scoreboard: RTL and testbench

PANDA_RISC_V_LIT_SCOREBOARD -- requirements
Module: panda_risc_v_lit_scoreboard

---
 rtl/panda_risc_v_pkg.sv | 19 +
 rtl/panda_risc_v_lit_scoreboard_if.sv | 42 ++++
 rtl/panda_risc_v_lit_match.sv | 22 ++
 rtl/panda_risc_v_lit_scoreboard.sv | 97 +++++++++
 tb/tb_panda_risc_v_lit_scoreboard.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/panda_risc_v_pkg.sv
// Shared panda_risc_v definitions used by the long-instruction scoreboard.
// Holds the table depth default, tag-width helper and long-instruction kinds.
package panda_risc_v_pkg;

    localparam int unsigned LIT_DEPTH_DEF = 4;
    localparam int unsigned RID_W         = 5;

    typedef enum logic [1:0] {
        LIT_TYPE_LOAD = 2'd0,
        LIT_TYPE_MUL  = 2'd1,
        LIT_TYPE_DIV  = 2'd2
    } lit_type_e;

    // A depth-2 table still needs a 1-bit tag.
    function automatic int unsigned lit_tag_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/panda_risc_v_lit_scoreboard_if.sv
// Dispatcher <-> long-instruction scoreboard signal bundle.
// The master side is the decoder/dispatcher; the slave side is the scoreboard.
interface panda_risc_v_lit_scoreboard_if
    import panda_risc_v_pkg::*;
#(
    parameter int unsigned LIT_DEPTH = LIT_DEPTH_DEF
);
    localparam int unsigned TAG_W = lit_tag_w(LIT_DEPTH);

    logic [RID_W-1:0] raw_dpc_check_rs1_id;
    logic [RID_W-1:0] raw_dpc_check_rs2_id;
    logic [RID_W-1:0] raw_dpc_check_rd_id;
    logic             rs1_raw_dpc;
    logic             rs2_raw_dpc;
    logic             rd_raw_dpc;

    logic             lit_alloc_valid;
    logic [RID_W-1:0] lit_alloc_rd_id;
    logic             lit_alloc_ready;
    logic [TAG_W-1:0] lit_alloc_tag;

    logic             lit_wbk_valid;
    logic [TAG_W-1:0] lit_wbk_tag;

    logic             lit_empty;
    logic             lit_err;

    modport master (
        output raw_dpc_check_rs1_id, raw_dpc_check_rs2_id, raw_dpc_check_rd_id,
        output lit_alloc_valid, lit_alloc_rd_id, lit_wbk_valid, lit_wbk_tag,
        input  rs1_raw_dpc, rs2_raw_dpc, rd_raw_dpc,
        input  lit_alloc_ready, lit_alloc_tag, lit_empty, lit_err
    );

    modport slave (
        input  raw_dpc_check_rs1_id, raw_dpc_check_rs2_id, raw_dpc_check_rd_id,
        input  lit_alloc_valid, lit_alloc_rd_id, lit_wbk_valid, lit_wbk_tag,
        output rs1_raw_dpc, rs2_raw_dpc, rd_raw_dpc,
        output lit_alloc_ready, lit_alloc_tag, lit_empty, lit_err
    );

endinterface

// File: rtl/panda_risc_v_lit_match.sv
// Compares one register index against every table entry; x0 never matches
// because it has no real producer to wait for.
module panda_risc_v_lit_match
    import panda_risc_v_pkg::*;
#(
    parameter int unsigned LIT_DEPTH = LIT_DEPTH_DEF
) (
    input  logic [RID_W-1:0]                chk_id,
    input  logic [LIT_DEPTH-1:0]            ent_vld,
    input  logic [LIT_DEPTH-1:0][RID_W-1:0] ent_rd,
    output logic                            hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LIT_DEPTH; i++) begin
            if (ent_vld[i] && (ent_rd[i] == chk_id)) hit = 1'b1;
        end
        if (chk_id == '0) hit = 1'b0;
    end

endmodule

// File: rtl/panda_risc_v_lit_scoreboard.sv
// Long-instruction table: tracks outstanding load/mul/div destinations and
// flags RAW dependencies for the dispatcher.
module panda_risc_v_lit_scoreboard
    import panda_risc_v_pkg::*;
#(
    parameter int unsigned LIT_DEPTH        = LIT_DEPTH_DEF,
    parameter int unsigned simulation_delay = 1
) (
    input logic                          clk,
    input logic                          sys_reset,
    panda_risc_v_lit_scoreboard_if.slave sb
);

    localparam int unsigned TAG_W = lit_tag_w(LIT_DEPTH);

    // simulation_delay only shapes behavioural models; here it is range-checked.
    if (!(LIT_DEPTH == 2 || LIT_DEPTH == 4 || LIT_DEPTH == 8) || (simulation_delay > 1000)) begin : g_param_chk
        $error("panda_risc_v_lit_scoreboard: illegal LIT_DEPTH or simulation_delay");
    end

    logic [LIT_DEPTH-1:0]            vld_q, vld_d;
    logic [LIT_DEPTH-1:0][RID_W-1:0] rd_q, rd_d;
    logic                            err_q, err_d;

    logic             free_found;
    logic [TAG_W-1:0] free_idx;
    logic             alloc_fire;
    logic             wbk_hit;

    // Lowest-index free entry, from registered state only.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = LIT_DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                free_found = 1'b1;
                free_idx   = TAG_W'(i);
            end
        end
    end

    assign alloc_fire = sb.lit_alloc_valid & free_found;
    assign wbk_hit    = sb.lit_wbk_valid & vld_q[sb.lit_wbk_tag];

    // A writeback to a free entry (including one being allocated now) is an error.
    always_comb begin
        vld_d = vld_q;
        rd_d  = rd_q;
        err_d = err_q;
        if (wbk_hit) begin
            vld_d[sb.lit_wbk_tag] = 1'b0;
        end else if (sb.lit_wbk_valid) begin
            err_d = 1'b1;
        end
        if (alloc_fire) begin
            vld_d[free_idx] = 1'b1;
            rd_d[free_idx]  = sb.lit_alloc_rd_id;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            vld_q <= '0;
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
            err_q <= err_d;
        end
    end

    logic [2:0][RID_W-1:0] chk_id;
    logic [2:0]            hit;

    assign chk_id = {sb.raw_dpc_check_rd_id, sb.raw_dpc_check_rs2_id, sb.raw_dpc_check_rs1_id};

    for (genvar g = 0; g < 3; g++) begin : g_match
        panda_risc_v_lit_match #(
            .LIT_DEPTH(LIT_DEPTH)
        ) u_match (
            .chk_id (chk_id[g]),
            .ent_vld(vld_q),
            .ent_rd (rd_q),
            .hit    (hit[g])
        );
    end

    assign sb.rs1_raw_dpc     = hit[0];
    assign sb.rs2_raw_dpc     = hit[1];
    assign sb.rd_raw_dpc      = hit[2];
    assign sb.lit_alloc_ready = free_found;
    assign sb.lit_alloc_tag   = free_idx;
    assign sb.lit_empty       = ~|vld_q;
    assign sb.lit_err         = err_q;

endmodule

// File: tb/tb_panda_risc_v_lit_scoreboard.sv
// Directed vector bench for the long-instruction scoreboard (LIT_DEPTH = 4).
module tb_panda_risc_v_lit_scoreboard;

    logic clk = 1'b0;
    logic sys_reset;

    always #5 clk = ~clk;

    panda_risc_v_lit_scoreboard_if #(.LIT_DEPTH(4)) sb_if ();

    panda_risc_v_lit_scoreboard #(
        .LIT_DEPTH       (4),
        .simulation_delay(1)
    ) dut (
        .clk      (clk),
        .sys_reset(sys_reset),
        .sb       (sb_if)
    );

    typedef struct {
        logic       rst;
        logic       av;
        logic [4:0] ard;
        logic       wv;
        logic [1:0] wt;
        logic [4:0] c1, c2, c3;
        logic       e1, e2, e3;
        logic       erdy;
        logic       chk_tag;
        logic [1:0] etag;
        logic       eempty;
        logic       eerr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] ard,
                                input logic wv, input logic [1:0] wt,
                                input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] c3,
                                input logic e1, input logic e2, input logic e3,
                                input logic erdy, input logic chk_tag, input logic [1:0] etag,
                                input logic eempty, input logic eerr);
        vec_t v;
        v.rst = rst; v.av = av; v.ard = ard; v.wv = wv; v.wt = wt;
        v.c1 = c1; v.c2 = c2; v.c3 = c3;
        v.e1 = e1; v.e2 = e2; v.e3 = e3;
        v.erdy = erdy; v.chk_tag = chk_tag; v.etag = etag;
        v.eempty = eempty; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic av, input logic [4:0] ard,
                         input logic wv, input logic [1:0] wt,
                         input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] c3);
        sys_reset                  = rst;
        sb_if.lit_alloc_valid      = av;
        sb_if.lit_alloc_rd_id      = ard;
        sb_if.lit_wbk_valid        = wv;
        sb_if.lit_wbk_tag          = wt;
        sb_if.raw_dpc_check_rs1_id = c1;
        sb_if.raw_dpc_check_rs2_id = c2;
        sb_if.raw_dpc_check_rd_id  = c3;
    endtask

    initial begin
        //          rst av ard wv wt  c1  c2  c3  e1 e2 e3 rdy ct tag emp err
        vecs.push_back(mk(0, 0,  0, 0, 0,  5,  3,  7, 0, 0, 0, 1, 1, 0, 1, 0)); // 0 post-reset
        vecs.push_back(mk(0, 1,  5, 0, 0,  5,  0,  0, 0, 0, 0, 1, 1, 0, 1, 0)); // 1 alloc rd5
        vecs.push_back(mk(0, 0,  0, 0, 0,  5,  5,  5, 1, 1, 1, 1, 1, 1, 0, 0)); // 2
        vecs.push_back(mk(0, 1,  3, 0, 0,  3,  5,  4, 0, 1, 0, 1, 1, 1, 0, 0)); // 3
        vecs.push_back(mk(0, 1,  4, 0, 0,  3,  4,  6, 1, 0, 0, 1, 1, 2, 0, 0)); // 4
        vecs.push_back(mk(0, 1,  6, 0, 0,  4,  6,  5, 1, 0, 1, 1, 1, 3, 0, 0)); // 5 fills
        vecs.push_back(mk(0, 1,  7, 0, 0,  7,  6,  0, 0, 1, 0, 0, 0, 0, 0, 0)); // 6 full
        vecs.push_back(mk(0, 0,  0, 1, 2,  4,  7,  0, 1, 0, 0, 0, 0, 0, 0, 0)); // 7 retire 2
        vecs.push_back(mk(0, 0,  0, 0, 0,  4,  3,  0, 0, 1, 0, 1, 1, 2, 0, 0)); // 8
        vecs.push_back(mk(0, 1,  7, 0, 0,  7,  0,  0, 0, 0, 0, 1, 1, 2, 0, 0)); // 9
        vecs.push_back(mk(0, 1,  9, 1, 0,  5,  9,  0, 1, 0, 0, 0, 0, 0, 0, 0)); // 10 full+retire
        vecs.push_back(mk(0, 1,  9, 0, 0,  5,  9,  7, 0, 0, 1, 1, 1, 0, 0, 0)); // 11
        vecs.push_back(mk(0, 0,  0, 0, 0,  9,  5,  0, 1, 0, 0, 0, 0, 0, 0, 0)); // 12
        vecs.push_back(mk(0, 0,  0, 1, 3,  6,  3,  0, 1, 1, 0, 0, 0, 0, 0, 0)); // 13
        vecs.push_back(mk(0, 1, 10, 1, 1,  6,  3, 10, 0, 1, 0, 1, 1, 3, 0, 0)); // 14 alloc+retire
        vecs.push_back(mk(0, 0,  0, 0, 0, 10,  3,  0, 1, 0, 0, 1, 1, 1, 0, 0)); // 15
        vecs.push_back(mk(0, 1,  0, 0, 0,  0,  0,  0, 0, 0, 0, 1, 1, 1, 0, 0)); // 16 alloc rd0
        vecs.push_back(mk(0, 0,  0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0)); // 17
        vecs.push_back(mk(0, 0,  0, 1, 2,  7,  0,  0, 1, 0, 0, 0, 0, 0, 0, 0)); // 18
        vecs.push_back(mk(0, 0,  0, 1, 2,  7, 10,  9, 0, 1, 1, 1, 1, 2, 0, 0)); // 19 bad retire
        vecs.push_back(mk(0, 0,  0, 0, 0,  9, 10,  0, 1, 1, 0, 1, 1, 2, 0, 1)); // 20
        vecs.push_back(mk(0, 1, 12, 1, 2, 12,  0,  0, 0, 0, 0, 1, 1, 2, 0, 1)); // 21 alloc k, retire k
        vecs.push_back(mk(0, 0,  0, 0, 0, 12,  9, 10, 1, 1, 1, 0, 0, 0, 0, 1)); // 22
        vecs.push_back(mk(1, 1,  8, 1, 0, 12,  8,  0, 1, 0, 0, 0, 0, 0, 0, 1)); // 23 reset
        vecs.push_back(mk(0, 0,  0, 0, 0, 12,  9, 10, 0, 0, 0, 1, 1, 0, 1, 0)); // 24
        vecs.push_back(mk(0, 1,  1, 0, 0,  1,  0,  0, 0, 0, 0, 1, 1, 0, 1, 0)); // 25
        vecs.push_back(mk(0, 1,  2, 0, 0,  1,  2,  0, 1, 0, 0, 1, 1, 1, 0, 0)); // 26
        vecs.push_back(mk(0, 1,  3, 0, 0,  1,  2,  3, 1, 1, 0, 1, 1, 2, 0, 0)); // 27
        vecs.push_back(mk(1, 0,  0, 0, 0,  1,  2,  3, 1, 1, 1, 1, 1, 3, 0, 0)); // 28 reset
        vecs.push_back(mk(0, 0,  0, 0, 0,  1,  2,  3, 0, 0, 0, 1, 1, 0, 1, 0)); // 29

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].wv, vecs[i].wt,
                  vecs[i].c1, vecs[i].c2, vecs[i].c3);
            #1;
            chk($sformatf("v%0d_rs1", i), 8'(sb_if.rs1_raw_dpc), 8'(vecs[i].e1));
            chk($sformatf("v%0d_rs2", i), 8'(sb_if.rs2_raw_dpc), 8'(vecs[i].e2));
            chk($sformatf("v%0d_rd", i), 8'(sb_if.rd_raw_dpc), 8'(vecs[i].e3));
            chk($sformatf("v%0d_ready", i), 8'(sb_if.lit_alloc_ready), 8'(vecs[i].erdy));
            if (vecs[i].chk_tag)
                chk($sformatf("v%0d_tag", i), 8'(sb_if.lit_alloc_tag), 8'(vecs[i].etag));
            chk($sformatf("v%0d_empty", i), 8'(sb_if.lit_empty), 8'(vecs[i].eempty));
            chk($sformatf("v%0d_err", i), 8'(sb_if.lit_err), 8'(vecs[i].eerr));
            @(posedge clk);
        end

        // Single entry through allocate -> visible -> retiring -> empty.
        @(negedge clk);
        drive(0, 1, 20, 0, 0, 20, 0, 0);
        #1;
        chk("h_alloc_rs1", 8'(sb_if.rs1_raw_dpc), 8'd0);
        chk("h_alloc_empty", 8'(sb_if.lit_empty), 8'd1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 20, 0, 0);
        #1;
        chk("h_live_rs1", 8'(sb_if.rs1_raw_dpc), 8'd1);
        chk("h_live_empty", 8'(sb_if.lit_empty), 8'd0);
        chk("h_live_tag", 8'(sb_if.lit_alloc_tag), 8'd1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 20, 0, 0);
        #1;
        chk("h_retiring_rs1", 8'(sb_if.rs1_raw_dpc), 8'd1);
        chk("h_retiring_empty", 8'(sb_if.lit_empty), 8'd0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 20, 0, 0);
        #1;
        chk("h_done_rs1", 8'(sb_if.rs1_raw_dpc), 8'd0);
        chk("h_done_empty", 8'(sb_if.lit_empty), 8'd1);
        chk("h_done_err", 8'(sb_if.lit_err), 8'd0);
        chk("h_done_tag", 8'(sb_if.lit_alloc_tag), 8'd0);
        @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
